// File: rtl/obj_bbox_tracker.sv
// obj_bbox_tracker: per-label bounding-box accumulator; on frame_end scans the label table and emits one record per non-empty label.
// Latency: pixel read-modify-write completes in 1 cycle; first record 1 cycle after frame_end, +1 cycle per skipped empty label.
// Backpressure: records use out_valid/out_ready; while busy, en/frame_end are dropped and flagged on overrun.
// Optional: define OBJ_BBOX_AREA_EN for per-label saturating pixel counters, out_area and the min_area filter input.
module obj_bbox_tracker #(
  parameter int LABEL_WIDTH = 8,
  parameter int COORD_WIDTH = 16,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  input  logic [LABEL_WIDTH-1:0] label,
  input  logic                   frame_end,
`ifdef OBJ_BBOX_AREA_EN
  input  logic [COUNT_WIDTH-1:0] min_area,
`endif
  output logic                   busy,
  output logic                   overrun,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LABEL_WIDTH-1:0] out_label,
  output logic [COORD_WIDTH-1:0] out_min_x,
  output logic [COORD_WIDTH-1:0] out_max_x,
  output logic [COORD_WIDTH-1:0] out_min_y,
  output logic [COORD_WIDTH-1:0] out_max_y,
  output logic [COUNT_WIDTH-1:0] out_area,
  output logic                   scan_done
);

  localparam int DEPTH = 1 << LABEL_WIDTH;
  localparam logic [LABEL_WIDTH-1:0] LAST_IDX = '1;
  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_SCAN  = 1'b1;

  logic                   r_state;
  logic [LABEL_WIDTH-1:0] r_idx;
  logic [DEPTH-1:0]       r_vld;
  logic                   r_overrun;
  logic                   r_scan_done;
  logic [COORD_WIDTH-1:0] r_min_x [DEPTH];
  logic [COORD_WIDTH-1:0] r_max_x [DEPTH];
  logic [COORD_WIDTH-1:0] r_min_y [DEPTH];
  logic [COORD_WIDTH-1:0] r_max_y [DEPTH];
`ifdef OBJ_BBOX_AREA_EN
  logic [COUNT_WIDTH-1:0] r_area  [DEPTH];
`endif

  logic w_scan;
  logic w_pix;
  logic w_hit;
  logic w_ent_vld;
  logic w_small;
  logic w_emit;
  logic w_adv;
  logic w_clr;

  assign w_scan    = (r_state == ST_SCAN);
  // Label 0 is background and never enters the table.
  assign w_pix     = !w_scan && en && (label != '0);
  assign w_hit     = r_vld[label];
  assign w_ent_vld = r_vld[r_idx];
`ifdef OBJ_BBOX_AREA_EN
  assign w_small   = w_ent_vld && (r_area[r_idx] < min_area);
`else
  assign w_small   = 1'b0;
`endif
  assign w_emit    = w_scan && w_ent_vld && !w_small;
  // An emitted entry holds the index until the consumer takes it; everything else advances immediately.
  assign w_adv     = w_scan && (!w_emit || out_ready);
  assign w_clr     = w_scan && w_ent_vld && (w_small || out_ready);

  // Control state, scan index, per-label valid bits and the status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ACCUM;
      r_idx       <= '0;
      r_vld       <= '0;
      r_overrun   <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_overrun   <= w_scan && (en || frame_end);
      r_scan_done <= 1'b0;
      if (!w_scan) begin
        if (w_pix) r_vld[label] <= 1'b1;
        if (frame_end) begin
          r_state <= ST_SCAN;
          r_idx   <= LABEL_WIDTH'(1);
        end
      end else begin
        if (w_clr) r_vld[r_idx] <= 1'b0;
        if (w_adv) begin
          if (r_idx == LAST_IDX) begin
            r_state     <= ST_ACCUM;
            r_scan_done <= 1'b1;
          end else begin
            r_idx <= r_idx + LABEL_WIDTH'(1);
          end
        end
      end
    end
  end

  // Box (and area) read-modify-write; contents of invalid entries are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (w_pix) begin
      if (!w_hit) begin
        r_min_x[label] <= x;
        r_max_x[label] <= x;
        r_min_y[label] <= y;
        r_max_y[label] <= y;
      end else begin
        if (x < r_min_x[label]) r_min_x[label] <= x;
        if (x > r_max_x[label]) r_max_x[label] <= x;
        if (y < r_min_y[label]) r_min_y[label] <= y;
        if (y > r_max_y[label]) r_max_y[label] <= y;
      end
`ifdef OBJ_BBOX_AREA_EN
      if (!w_hit) r_area[label] <= COUNT_WIDTH'(1);
      else if (r_area[label] != '1) r_area[label] <= r_area[label] + COUNT_WIDTH'(1);
`endif
    end
  end

  assign busy      = w_scan;
  assign overrun   = r_overrun;
  assign scan_done = r_scan_done;
  assign out_valid = w_emit;
  assign out_label = w_emit ? r_idx : '0;
  assign out_min_x = w_emit ? r_min_x[r_idx] : '0;
  assign out_max_x = w_emit ? r_max_x[r_idx] : '0;
  assign out_min_y = w_emit ? r_min_y[r_idx] : '0;
  assign out_max_y = w_emit ? r_max_y[r_idx] : '0;
`ifdef OBJ_BBOX_AREA_EN
  assign out_area  = w_emit ? r_area[r_idx] : '0;
`else
  assign out_area  = '0;
`endif

endmodule

// File: tb/tb_obj_bbox_tracker.sv
// tb_obj_bbox_tracker: directed self-checking bench for obj_bbox_tracker.
// With OBJ_BBOX_AREA_EN the DUT is built with a 4-bit pixel counter so saturation is reachable quickly.
module tb_obj_bbox_tracker;
`ifdef OBJ_BBOX_AREA_EN
  localparam int CW = 4;
  localparam bit AREA_ON = 1'b1;
`else
  localparam int CW = 20;
  localparam bit AREA_ON = 1'b0;
`endif
  localparam int RW = 8 + 4*16 + CW;
  typedef logic [RW-1:0] rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic [7:0] label = '0;
  logic frame_end = 1'b0;
  logic [CW-1:0] min_area = '0;
  logic busy, overrun, out_valid, scan_done;
  logic out_ready = 1'b0;
  logic [7:0] out_label;
  logic [15:0] out_min_x, out_max_x, out_min_y, out_max_y;
  logic [CW-1:0] out_area;

  int checks = 0;
  int errors = 0;
  rec_t recs[$];
  int busy_cnt;
  int first_at;
  bit done_seen;

  obj_bbox_tracker #(.LABEL_WIDTH(8), .COORD_WIDTH(16), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .y(y), .label(label),
    .frame_end(frame_end),
`ifdef OBJ_BBOX_AREA_EN
    .min_area(min_area),
`endif
    .busy(busy), .overrun(overrun), .out_valid(out_valid), .out_ready(out_ready),
    .out_label(out_label), .out_min_x(out_min_x), .out_max_x(out_max_x),
    .out_min_y(out_min_y), .out_max_y(out_max_y), .out_area(out_area),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  function automatic rec_t mk(input int l, input int x0, input int x1, input int y0, input int y1, input int a);
    return {8'(l), 16'(x0), 16'(x1), 16'(y0), 16'(y1), CW'(a)};
  endfunction

  function automatic rec_t cur();
    return {out_label, out_min_x, out_max_x, out_min_y, out_max_y, out_area};
  endfunction

  // All tasks are entered and left at a falling edge.
  task automatic pix(input int l, input int px, input int py);
    en = 1'b1; label = 8'(l); x = 16'(px); y = 16'(py);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic fend();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  // Drains a scan with out_ready high, collecting records; bounded.
  task automatic run_scan();
    out_ready = 1'b1;
    recs.delete();
    busy_cnt = 0; first_at = -1; done_seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy) busy_cnt++;
      if (out_valid) begin
        if (first_at < 0) first_at = busy_cnt;
        recs.push_back(cur());
      end
      if (scan_done) begin
        done_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, overrun, out_valid, scan_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {busy, overrun, out_valid, scan_done});
    end
    checks++;
    if (cur() !== rec_t'(0)) begin
      errors++; $display("FAIL reset_record got %h exp 0", cur());
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    rec_t exp = mk(5, 3, 7, 2, 9, AREA_ON ? 3 : 0);
    pix(5, 3, 4); pix(5, 7, 2); pix(5, 5, 9);
    fend();
    run_scan();
    checks++;
    if (!done_seen) begin errors++; $display("FAIL basic_done got 0 exp 1"); end
    checks++;
    if (recs.size() != 1) begin errors++; $display("FAIL basic_count got %0d exp 1", recs.size()); end
    else begin
      checks++;
      if (recs[0] !== exp) begin errors++; $display("FAIL basic_record got %h exp %h", recs[0], exp); end
    end
    checks++;
    if (first_at != 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", first_at); end
    checks++;
    if (busy_cnt != 255) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 255", busy_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    rec_t exp2 = mk(2, 11, 11, 12, 12, AREA_ON ? 1 : 0);
    rec_t exp200 = mk(200, 20, 20, 21, 21, AREA_ON ? 1 : 0);
    pix(2, 11, 12); pix(200, 20, 21);
    out_ready = 1'b0;
    fend();
    wait_valid(ok);
    checks++;
    if (!ok || cur() !== exp2) begin errors++; $display("FAIL bp_first got %h exp %h", cur(), exp2); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || cur() !== exp2) begin
        errors++; $display("FAIL bp_hold_%0d got v=%b %h exp v=1 %h", i, out_valid, cur(), exp2);
      end
    end
    run_scan();
    checks++;
    if (!done_seen || recs.size() != 2) begin
      errors++; $display("FAIL bp_count got %0d done=%b exp 2 done=1", recs.size(), done_seen);
    end else begin
      checks++;
      if (recs[0] !== exp2 || recs[1] !== exp200) begin
        errors++; $display("FAIL bp_records got %h %h exp %h %h", recs[0], recs[1], exp2, exp200);
      end
    end
    fend();
    run_scan();
    checks++;
    if (!done_seen || recs.size() != 0) begin
      errors++; $display("FAIL bp_cleared got %0d done=%b exp 0 done=1", recs.size(), done_seen);
    end
  endtask

  task automatic test_en_with_frame_end();
    rec_t exp = mk(9, 1, 5, 1, 6, AREA_ON ? 2 : 0);
    pix(0, 0, 0);
    pix(9, 5, 6);
    en = 1'b1; label = 8'd9; x = 16'd1; y = 16'd1; frame_end = 1'b1;
    @(negedge clk);
    en = 1'b0; frame_end = 1'b0;
    run_scan();
    checks++;
    if (!done_seen || recs.size() != 1) begin
      errors++; $display("FAIL coinc_count got %0d done=%b exp 1 done=1", recs.size(), done_seen);
    end else begin
      checks++;
      if (recs[0] !== exp) begin errors++; $display("FAIL coinc_record got %h exp %h", recs[0], exp); end
    end
  endtask

  task automatic test_overrun();
    rec_t exp3 = mk(3, 10, 10, 10, 10, AREA_ON ? 1 : 0);
    pix(7, 30, 31);
    out_ready = 1'b0;
    fend();
    en = 1'b1; label = 8'd3; x = 16'd50; y = 16'd50;
    @(negedge clk);
    en = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pixel got %b exp 1", overrun); end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pulse_end got %b exp 0", overrun); end
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_frame_end got %b exp 1", overrun); end
    run_scan();
    checks++;
    if (!done_seen || recs.size() != 1 || recs[0][RW-1 -: 8] !== 8'd7) begin
      errors++; $display("FAIL ovr_scan got %0d recs done=%b exp 1 rec label 7", recs.size(), done_seen);
    end
    pix(3, 10, 10);
    fend();
    run_scan();
    checks++;
    if (!done_seen || recs.size() != 1) begin
      errors++; $display("FAIL ovr_next_count got %0d done=%b exp 1", recs.size(), done_seen);
    end else begin
      checks++;
      if (recs[0] !== exp3) begin errors++; $display("FAIL ovr_next_record got %h exp %h", recs[0], exp3); end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    pix(4, 1, 2);
    out_ready = 1'b0;
    fend();
    wait_valid(ok);
    checks++;
    if (!ok || out_label !== 8'd4) begin errors++; $display("FAIL rst_pending got %0d exp 4", out_label); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({out_valid, busy, scan_done} !== 3'b000 || cur() !== rec_t'(0)) begin
      errors++; $display("FAIL rst_abandon got v/b/d=%b rec %h exp 000 0", {out_valid, busy, scan_done}, cur());
    end
    fend();
    run_scan();
    checks++;
    if (!done_seen || recs.size() != 0 || busy_cnt != 255) begin
      errors++; $display("FAIL rst_empty_scan got %0d recs busy %0d done=%b exp 0 255 1", recs.size(), busy_cnt, done_seen);
    end
  endtask

  task automatic test_area();
    rec_t exp1 = mk(1, 0, 20, 0, 20, AREA_ON ? 15 : 0);
    rec_t exp6 = mk(6, 8, 9, 8, 9, AREA_ON ? 2 : 0);
    for (int i = 0; i < 21; i++) pix(1, i, 20 - i);
    fend();
    run_scan();
    checks++;
    if (!done_seen || recs.size() != 1 || recs[0] !== exp1) begin
      errors++; $display("FAIL area_sat got %0d recs %h exp 1 %h", recs.size(), recs.size() > 0 ? recs[0] : rec_t'(0), exp1);
    end
    checks++;
    if (first_at != 1) begin errors++; $display("FAIL label1_latency got %0d exp 1", first_at); end
    min_area = CW'(2);
    pix(4, 3, 3);
    pix(6, 8, 8); pix(6, 9, 9);
    fend();
    run_scan();
    checks++;
    if (AREA_ON) begin
      if (!done_seen || recs.size() != 1 || recs[0] !== exp6) begin
        errors++; $display("FAIL area_filter got %0d recs exp 1 rec %h", recs.size(), exp6);
      end
    end else begin
      if (!done_seen || recs.size() != 2 || recs[1] !== exp6) begin
        errors++; $display("FAIL area_nofilter got %0d recs exp 2 last %h", recs.size(), exp6);
      end
    end
    min_area = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_en_with_frame_end();
    test_overrun();
    test_reset_mid_scan();
    test_area();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obj_bbox_tracker.md
Name: obj_bbox_tracker

Overview:
- Downstream stage of the labelling pipeline: consumes the per-pixel component label stream (one label per enabled pixel, with x/y) and accumulates a bounding box per label over a frame.
- On frame end, scans the label table and emits one record per non-empty label over a valid/ready handshake, then clears the table for the next frame.
- Feeds the host readout / overlay logic.

Parameters:
- LABEL_WIDTH, 8, label width; table depth is 2^LABEL_WIDTH entries; label 0 is background.
- COORD_WIDTH, 16, width of x/y coordinates.
- COUNT_WIDTH, 20, pixel-count width (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  pixel strobe; x/y/label are valid when high
- x  in  COORD_WIDTH  pixel column
- y  in  COORD_WIDTH  pixel row
- label  in  LABEL_WIDTH  component label of the pixel
- frame_end  in  1  single-cycle pulse after the last pixel of a frame
- busy  out  1  high while scanning; pixels are not accepted
- overrun  out  1  one-cycle pulse when en or frame_end arrives while busy
- out_valid  out  1  record valid
- out_ready  in  1  consumer accepts the record
- out_label  out  LABEL_WIDTH  record label
- out_min_x, out_max_x, out_min_y, out_max_y  out  COORD_WIDTH each  bounding box, inclusive
- out_area  out  COUNT_WIDTH  pixel count (0 when the feature is absent)
- scan_done  out  1  one-cycle pulse when a scan completes

Behaviour:
- Reset:
  - Clears every per-label valid bit. Box contents are don't-care.
  - State goes to ACCUM. busy, overrun, out_valid and scan_done go to 0. Record outputs go to 0.
  - Reset during SCAN abandons the scan immediately; no further records are emitted.
- Table: register array with a combinational read, so each pixel's read-modify-write completes in one cycle. Back-to-back pixels with the same label need no hazard logic.
- ACCUM, on en with label != 0:
  - Entry invalid: set valid; min = max = x/y; area = 1.
  - Entry valid: min_x = min(min_x, x), and likewise for max_x, min_y, max_y (unsigned compare); area saturates at all-ones.
  - label == 0 is ignored.
- ACCUM, on frame_end: go to SCAN with index = 1. If en and frame_end are high together, the pixel is accumulated first, then the scan starts the next cycle.
- SCAN (busy = 1):
  - Each cycle examines the entry at index.
  - Entry invalid: advance index; no output.
  - Entry valid: drive out_valid = 1 with the entry fields. Hold them stable until out_ready. On the handshake cycle, clear the valid bit and advance index.
  - out_valid never drops without a handshake. out_ready while out_valid = 0 is ignored.
  - An empty table takes 2^LABEL_WIDTH − 1 cycles to scan.
- Scan end: after index 2^LABEL_WIDTH − 1 is processed, index wraps and is not reused. Pulse scan_done for one cycle, deassert busy the same cycle, and return to ACCUM. Pixels are accepted from that cycle onward.
- While busy: en and frame_end are dropped and overrun pulses once per offending cycle. Table contents are unaffected apart from scan clears.
- Latency:
  - First record is visible 1 cycle after frame_end if label 1 is valid.
  - Otherwise, one cycle per skipped empty label.

Optional Feature:
- Macro: OBJ_BBOX_AREA_EN.
- Defined:
  - Per-label COUNT_WIDTH saturating pixel counter.
  - out_area carries it.
  - Extra input min_area [COUNT_WIDTH−1:0]. During SCAN, valid entries with area < min_area are cleared and skipped in one cycle without asserting out_valid.
- Undefined:
  - No counters and no min_area port.
  - out_area is tied to 0.
  - Every valid entry is emitted.

Test Plan:
- Pixels (3,4), (7,2), (5,9) with label 5, then frame_end, out_ready = 1 → exactly one record: label 5, min_x 3, max_x 7, min_y 2, max_y 9, area 3 (feature on); then scan_done; busy is high for 255 cycles.
- Labels 2 and 200 each get one pixel; out_ready held 0 for 10 cycles → out_valid held with label 2 and stable fields; after release, the label 200 record follows; the next frame starts with an empty table.
- en on the same cycle as frame_end (label 9, x = 1, y = 1) → the label 9 record includes (1,1); pixels with label 0 never produce records.
- Pixels during SCAN → each is dropped with an overrun pulse; after scan_done, a new pixel (label 3, x 10, y 10) yields box 10/10/10/10 next frame.
- reset asserted mid-scan with a record pending → out_valid drops the next cycle; busy = 0; a following frame_end with no pixels gives scan_done only.
- Feature on, min_area = 2: label 4 with 1 pixel, label 6 with 2 pixels → only the label 6 record; 2^20 + 5 pixels on one label → area = 0xFFFFF.
